// File: rtl/dsp_lut_iq_pkg.sv
// Shared types and helpers for the multi-channel IQ LUT requantiser.
// The LUT is addressed in offset-binary, so a sample's MSB is flipped to form its address.
package dsp_lut_iq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic [31:0] lut_addr(input logic [31:0] sample, input int width);
    return sample ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/dsp_lut_iq_mc_if.sv
// Sample/result bus plus LUT configuration port of the IQ LUT requantiser.
// Handshake: a block is taken on a clock where we && ready; valid pulses for one cycle when i_out/q_out update.
interface dsp_lut_iq_mc_if
  import dsp_lut_iq_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 3,
  parameter int CNT_WIDTH = 16
);
  logic                     we;
  logic [NCH*IN_WIDTH-1:0]  i_in;
  logic [NCH*IN_WIDTH-1:0]  q_in;
  logic                     ready;
  logic [NCH*OUT_WIDTH-1:0] i_out;
  logic [NCH*OUT_WIDTH-1:0] q_out;
  logic                     valid;
  logic                     cfg_we;
  logic [IN_WIDTH-1:0]      cfg_addr;
  logic [OUT_WIDTH-1:0]     cfg_data;
  logic                     cfg_swap;
  logic                     cfg_active;
  logic [CNT_WIDTH-1:0]     drop_cnt;
  state_t                   dbg_state;

  modport master (
    output we, i_in, q_in, cfg_we, cfg_addr, cfg_data, cfg_swap,
    input  ready, i_out, q_out, valid, cfg_active, drop_cnt, dbg_state
  );

  modport slave (
    input  we, i_in, q_in, cfg_we, cfg_addr, cfg_data, cfg_swap,
    output ready, i_out, q_out, valid, cfg_active, drop_cnt, dbg_state
  );
endinterface

// File: rtl/dsp_lut_dpram.sv
// Simple dual-port RAM holding both LUT banks; bank select is the address MSB.
// One write port, one registered read port, single clock; contents are not reset.
module dsp_lut_dpram #(
  parameter int AW = 9,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end
endmodule

// File: rtl/dsp_lut_iq_mc.sv
// Multi-channel IQ LUT requantiser: maps 2*NCH samples per block through one shared,
// double-buffered LUT, one RAM read per cycle, and presents all results with a one-cycle valid.
module dsp_lut_iq_mc
  import dsp_lut_iq_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input logic          clk,
  input logic          reset,
  dsp_lut_iq_mc_if.slave bus
);
  localparam int NS = 2 * NCH;
  localparam int KW = $clog2(NS);

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [IN_WIDTH-1:0]      samp_q [NS];
  logic [IN_WIDTH-1:0]      samp_d [NS];
  logic [OUT_WIDTH-1:0]     shad_q [NS];
  logic [OUT_WIDTH-1:0]     shad_d [NS];
  logic [NCH*OUT_WIDTH-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic                     valid_q, valid_d;
  logic                     active_q, active_d, pend_q, pend_d, bank_q, bank_d;
  logic [CNT_WIDTH-1:0]     drop_q, drop_d;
  logic                     swap_now;
  logic [OUT_WIDTH-1:0]     rd_data;
  logic [IN_WIDTH:0]        rd_addr, wr_addr;

  // Reads always use the bank captured with the block; writes always target the idle bank.
  assign rd_addr = {bank_q, IN_WIDTH'(lut_addr(32'(samp_q[k_q]), IN_WIDTH))};
  assign wr_addr = {~active_q, bus.cfg_addr};

  dsp_lut_dpram #(.AW(IN_WIDTH + 1), .DW(OUT_WIDTH)) u_ram (
    .clk       (clk),
    .we_i      (bus.cfg_we),
    .wr_addr_i (wr_addr),
    .wr_data_i (bus.cfg_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    samp_d   = samp_q;
    shad_d   = shad_q;
    i_out_d  = i_out_q;
    q_out_d  = q_out_q;
    valid_d  = 1'b0;
    active_d = active_q;
    pend_d   = pend_q | bus.cfg_swap;
    bank_d   = bank_q;
    drop_d   = drop_q;
    // A swap requested in the same idle cycle as a strobe already applies to that block.
    swap_now = (state_q == IDLE) && (pend_q || bus.cfg_swap);
    if (swap_now) begin
      active_d = ~active_q;
      pend_d   = 1'b0;
    end
    if (bus.we && (state_q != IDLE) && (drop_q != '1)) drop_d = drop_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.we) begin
          for (int c = 0; c < NCH; c++) begin
            samp_d[2*c]   = bus.i_in[c*IN_WIDTH +: IN_WIDTH];
            samp_d[2*c+1] = bus.q_in[c*IN_WIDTH +: IN_WIDTH];
          end
          bank_d  = active_q ^ swap_now;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (k_q != '0) shad_d[k_q - 1'b1] = rd_data;
        if (k_q == KW'(NS - 1)) state_d = FLUSH;
        else                    k_d     = k_q + 1'b1;
      end
      FLUSH: begin
        shad_d[NS-1] = rd_data;
        for (int c = 0; c < NCH; c++) begin
          i_out_d[c*OUT_WIDTH +: OUT_WIDTH] = shad_d[2*c];
          q_out_d[c*OUT_WIDTH +: OUT_WIDTH] = shad_d[2*c+1];
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      samp_q   <= '{default: '0};
      shad_q   <= '{default: '0};
      i_out_q  <= '0;
      q_out_q  <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      pend_q   <= 1'b0;
      bank_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      samp_q   <= samp_d;
      shad_q   <= shad_d;
      i_out_q  <= i_out_d;
      q_out_q  <= q_out_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      bank_q   <= bank_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.i_out      = i_out_q;
  assign bus.q_out      = q_out_q;
  assign bus.valid      = valid_q;
  assign bus.cfg_active = active_q;
  assign bus.drop_cnt   = drop_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_dsp_lut_iq_mc.sv
// Directed bench for dsp_lut_iq_mc: bank programming, swap timing, throughput, drops, reset mid-block.
module tb_dsp_lut_iq_mc;
  import dsp_lut_iq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_lut_iq_mc_if #(.NCH(2), .IN_WIDTH(8), .OUT_WIDTH(3), .CNT_WIDTH(16)) bif ();
  dsp_lut_iq_mc_if #(.NCH(2), .IN_WIDTH(8), .OUT_WIDTH(3), .CNT_WIDTH(4))  bif2 ();

  dsp_lut_iq_mc #(.NCH(2), .IN_WIDTH(8), .OUT_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );
  dsp_lut_iq_mc #(.NCH(2), .IN_WIDTH(8), .OUT_WIDTH(3), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bif2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fills the inactive bank; table T is sample>>>5, inverted table is its bitwise complement.
  task automatic prog_bank(input bit inv);
    logic signed [7:0] s;
    logic signed [7:0] e;
    for (int a = 0; a < 256; a++) begin
      s = 8'(a) ^ 8'h80;
      e = s >>> 5;
      if (inv) e = ~e;
      bif.cfg_we   = 1'b1;
      bif.cfg_addr = 8'(a);
      bif.cfg_data = e[2:0];
      tick();
    end
    bif.cfg_we = 1'b0;
  endtask

  // Waits (bounded) for the valid pulse, then checks latency and mapped outputs.
  task automatic run_block(input int start_cyc, input string tag,
                           input logic [5:0] ie, input logic [5:0] qe);
    int cyc = start_cyc;
    while (bif.valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd6);
    check({tag, "_i"}, 32'(bif.i_out), 32'(ie));
    check({tag, "_q"}, 32'(bif.q_out), 32'(qe));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int vcnt;
    bif.we = 0;  bif.i_in = '0;  bif.q_in = '0;
    bif.cfg_we = 0;  bif.cfg_addr = '0;  bif.cfg_data = '0;  bif.cfg_swap = 0;
    bif2.we = 0; bif2.i_in = '0; bif2.q_in = '0;
    bif2.cfg_we = 0; bif2.cfg_addr = '0; bif2.cfg_data = '0; bif2.cfg_swap = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_ready", 32'(bif.ready), 32'd1);
    check("rst_valid", 32'(bif.valid), 32'd0);
    check("rst_i_out", 32'(bif.i_out), 32'd0);
    check("rst_q_out", 32'(bif.q_out), 32'd0);
    check("rst_active", 32'(bif.cfg_active), 32'd0);
    check("rst_drop", 32'(bif.drop_cnt), 32'd0);
    check("rst_state", 32'(bif.dbg_state), 32'(IDLE));

    // 1: program bank1 with T, swap, one block
    prog_bank(1'b0);
    bif.cfg_swap = 1'b1;
    tick();
    bif.cfg_swap = 1'b0;
    check("t1_active", 32'(bif.cfg_active), 32'd1);
    bif.i_in = {8'h80, 8'h7F};
    bif.q_in = {8'hFF, 8'h00};
    bif.we = 1'b1;
    tick();
    bif.we = 1'b0;
    check("t1_busy", 32'(bif.ready), 32'd0);
    run_block(1, "t1", 6'b100_011, 6'b111_000);
    check("t1_ready_on_valid", 32'(bif.ready), 32'd1);
    tick();
    check("t1_pulse", 32'(bif.valid), 32'd0);
    check("t1_hold_i", 32'(bif.i_out), 32'(6'b100_011));

    // 2: we held high for 30 cycles
    bif.i_in = {8'd64, 8'hDF};
    bif.q_in = {8'hE0, 8'h1F};
    bif.we = 1'b1;
    acc = 0;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (bif.ready) acc++;
      tick();
      if (bif.valid) vcnt++;
    end
    bif.we = 1'b0;
    repeat (10) begin
      tick();
      if (bif.valid) vcnt++;
    end
    check("t2_accepts", 32'(acc), 32'd5);
    check("t2_valids", 32'(vcnt), 32'd5);
    check("t2_drop", 32'(bif.drop_cnt), 32'd25);
    check("t2_i", 32'(bif.i_out), 32'(6'b010_110));
    check("t2_q", 32'(bif.q_out), 32'(6'b111_000));

    // 3: fill bank0 with inverted table, swap requested mid-block
    prog_bank(1'b1);
    bif.i_in = {8'h80, 8'h7F};
    bif.q_in = {8'hFF, 8'h00};
    bif.we = 1'b1;
    tick();
    bif.we = 1'b0;
    tick();
    bif.cfg_swap = 1'b1;
    tick();
    bif.cfg_swap = 1'b0;
    check("t3_active_hold", 32'(bif.cfg_active), 32'd1);
    run_block(3, "t3", 6'b100_011, 6'b111_000);
    tick();
    check("t3_active_toggled", 32'(bif.cfg_active), 32'd0);
    bif.we = 1'b1;
    tick();
    bif.we = 1'b0;
    run_block(1, "t3b", 6'b011_100, 6'b000_111);
    tick();

    // 6: swap and strobe in the same idle cycle
    bif.cfg_swap = 1'b1;
    bif.we = 1'b1;
    tick();
    bif.cfg_swap = 1'b0;
    bif.we = 1'b0;
    check("t6_active", 32'(bif.cfg_active), 32'd1);
    run_block(1, "t6", 6'b100_011, 6'b111_000);
    tick();

    // 4: reset for one cycle in cycle 3 of a block
    bif.we = 1'b1;
    tick();
    bif.we = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t4_i_async", 32'(bif.i_out), 32'd0);
    check("t4_q_async", 32'(bif.q_out), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t4_ready", 32'(bif.ready), 32'd1);
    vcnt = 0;
    repeat (10) begin
      tick();
      if (bif.valid) vcnt++;
    end
    check("t4_no_valid", 32'(vcnt), 32'd0);
    check("t4_i", 32'(bif.i_out), 32'd0);
    check("t4_q", 32'(bif.q_out), 32'd0);
    check("t4_active", 32'(bif.cfg_active), 32'd0);
    check("t4_drop", 32'(bif.drop_cnt), 32'd0);

    // 5: 4-bit drop counter saturates
    bif2.we = 1'b1;
    repeat (10) tick();
    check("t5_drop_partial", 32'(bif2.drop_cnt), 32'd8);
    repeat (14) tick();
    check("t5_drop_sat", 32'(bif2.drop_cnt), 32'd15);
    repeat (12) tick();
    bif2.we = 1'b0;
    tick();
    check("t5_drop_hold", 32'(bif2.drop_cnt), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
